seq_detect_param: RTL and testbench

//   Runtime-programmable serial bit-sequence detector for a valid-qualified 1-bit stream.

---
 rtl/seq_detect_param.sv | 110 +++++++++++
 tb/tb_seq_detect_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with registered match pulse and saturating counter.
// Optional build macro SEQ_DETECT_MASK_EN adds cfg_mask (per-position don't-care bits).
module seq_detect_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = 'h06,
   parameter int                 RST_LEN     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               data,
   input  logic               data_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
`ifdef SEQ_DETECT_MASK_EN
   input  logic [MAX_LEN-1:0] cfg_mask,
`endif
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   logic [MAX_LEN-1:0] pattern_q;
   logic [MAX_LEN-1:0] mask_q;
   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] win;
   logic [MAX_LEN-1:0] diff;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   cfg_len_clamped;
   logic               overlap_q;
   logic               hit;

   // Only the previous MAX_LEN-1 bits ever reach the compare window, so the
   // oldest history bit is not stored.
   logic [MAX_LEN-2:0] hist_q;

`ifdef SEQ_DETECT_MASK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
      end else if (cfg_load) begin
         mask_q <= cfg_mask;
      end
   end
`else
   assign mask_q = '0;
`endif

   always_comb begin
      cfg_len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      win             = {hist_q, data};
      len_mask        = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
      diff = (win ^ pattern_q) & len_mask & ~mask_q;
      hit  = data_valid && !cfg_load && (len_q != '0) &&
             (fill_q >= (len_q - LEN_W'(1))) && (diff == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q <= RST_PATTERN;
         len_q     <= LEN_W'(RST_LEN);
         overlap_q <= 1'b1;
         hist_q    <= '0;
         fill_q    <= '0;
         match     <= 1'b0;
      end else if (cfg_load) begin
         pattern_q <= cfg_pattern;
         len_q     <= cfg_len_clamped;
         overlap_q <= cfg_overlap;
         hist_q    <= '0;
         fill_q    <= '0;
         match     <= 1'b0;
      end else begin
         match <= hit;
         if (data_valid) begin
            if (hit && !overlap_q) begin
               hist_q <= '0;
               fill_q <= '0;
            end else begin
               hist_q <= win[MAX_LEN-2:0];
               if (fill_q != LEN_MAX) begin
                  fill_q <= fill_q + LEN_W'(1);
               end
            end
         end
      end
   end

   // Clear beats a coincident hit; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (hit && (match_cnt != CNT_SAT)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a queue-of-bits reference model predicts each cycle's
// match/match_cnt, a separate monitor pops and compares after every rising edge.
module tb_seq_detect_param;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic               clk         = 1'b0;
   logic               rst_n       = 1'b0;
   logic               data        = 1'b0;
   logic               data_valid  = 1'b0;
   logic               cfg_load    = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len     = '0;
   logic               cfg_overlap = 1'b0;
   logic [MAX_LEN-1:0] cfg_mask    = '0;
   logic               cnt_clr     = 1'b0;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit m;
      int c;
   } exp_t;
   exp_t exp_q[$];

   // reference model: the valid bits seen since the last flush, newest at the back
   bit                 bits_m[$];
   logic [MAX_LEN-1:0] pat_m;
   logic [MAX_LEN-1:0] mask_m;
   int                 len_m;
   bit                 ov_m;
   int                 cnt_m;

   seq_detect_param #(
      .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
      .RST_PATTERN(8'h06), .RST_LEN(3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (data),
      .data_valid (data_valid),
      .cfg_load   (cfg_load),
      .cfg_pattern(cfg_pattern),
      .cfg_len    (cfg_len),
      .cfg_overlap(cfg_overlap),
`ifdef SEQ_DETECT_MASK_EN
      .cfg_mask   (cfg_mask),
`endif
      .cnt_clr    (cnt_clr),
      .match      (match),
      .match_cnt  (match_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      bits_m.delete();
      pat_m  = 8'h06;
      mask_m = '0;
      len_m  = 3;
      ov_m   = 1'b1;
      cnt_m  = 0;
   endtask

   // Called at a falling edge: drive one cycle, predict its outcome, wait for the next falling edge.
   task automatic step(input bit d, input bit v, input bit ld, input bit clr);
      exp_t e;
      bit   hit;
      hit        = 1'b0;
      data       = d;
      data_valid = v;
      cfg_load   = ld;
      cnt_clr    = clr;
      if (ld) begin
         pat_m = cfg_pattern;
         len_m = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
         ov_m  = cfg_overlap;
`ifdef SEQ_DETECT_MASK_EN
         mask_m = cfg_mask;
`else
         mask_m = '0;
`endif
         bits_m.delete();
      end else if (v) begin
         bits_m.push_back(d);
         if (bits_m.size() > MAX_LEN) void'(bits_m.pop_front());
         if (len_m > 0 && bits_m.size() >= len_m) begin
            hit = 1'b1;
            for (int i = 0; i < len_m; i++) begin
               if (!mask_m[i] && bits_m[bits_m.size() - 1 - i] != pat_m[i]) hit = 1'b0;
            end
         end
         if (hit && !ov_m) bits_m.delete();
      end
      if (clr) cnt_m = 0;
      else if (hit && cnt_m < CNT_SAT) cnt_m++;
      e.m = hit;
      e.c = cnt_m;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic send(input bit b);
      step(b, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic send_seq(input logic [15:0] seq, input int n, input int gap = 0);
      for (int i = n - 1; i >= 0; i--) begin
         send(seq[i]);
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic clr_cnt();
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input int l, input bit ov,
                       input bit d = 1'b0, input bit v = 1'b0);
      cfg_pattern = p;
      cfg_len     = LEN_W'(l);
      cfg_overlap = ov;
      step(d, v, 1'b1, 1'b0);
   endtask

   // Asynchronous reset pulse placed entirely inside the clock-low phase.
   task automatic pulse_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_match", match, 0);
      chk("rst_cnt", match_cnt, 0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("match", match, e.m);
         chk("match_cnt", match_cnt, e.c);
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      model_reset();
      @(negedge clk);
      chk("init_match", match, 0);
      chk("init_cnt", match_cnt, 0);
      rst_n = 1'b1;

      // reset defaults: pattern 110 (newest bit0), len 3, overlapping
      send_seq(16'b0110, 4);
      chk("dflt_match", match, 1);
      chk("dflt_cnt", match_cnt, 1);

      // same sequence with 3 idle cycles between bits
      clr_cnt();
      load(8'h06, 3, 1'b1);
      send_seq(16'b0110, 4, 3);
      chk("gap_cnt", match_cnt, 1);

      // overlap on / off
      clr_cnt();
      load(8'h05, 4, 1'b1);
      send_seq(16'b0101010, 7);
      chk("ovl1_cnt", match_cnt, 2);
      clr_cnt();
      load(8'h05, 4, 1'b0);
      send_seq(16'b0101010, 7);
      chk("ovl0_cnt", match_cnt, 1);

      // load mid-stream discards the coincident bit and the history
      clr_cnt();
      load(8'h06, 3, 1'b1);
      send_seq(16'b011, 3);
      load(8'h03, 2, 1'b1, 1'b0, 1'b1);
      chk("ld_match", match, 0);
      send_seq(16'b11, 2);
      chk("ld_match1", match, 1);
      send(1'b1);
      chk("ld_match2", match, 1);
      chk("ld_cnt", match_cnt, 2);

      // counter saturation and clear beating a hit
      clr_cnt();
      load(8'h01, 1, 1'b1);
      repeat (5) send(1'b1);
      chk("sat_cnt", match_cnt, CNT_SAT);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("clr_hit_match", match, 1);
      chk("clr_hit_cnt", match_cnt, 0);

      // len 0 never matches
      load(8'hFF, 0, 1'b1);
      repeat (64) send(1'($urandom_range(0, 1)));
      chk("len0_cnt", match_cnt, 0);

      // len 9 clamps to 8
      clr_cnt();
      load(8'hA5, 9, 1'b1);
      send_seq(16'h00A5, 8);
      chk("len9_match", match, 1);
      chk("len9_cnt", match_cnt, 1);
      repeat (64) send(1'($urandom_range(0, 1)));

      // reset in the middle of 0110 must not complete it
      load(8'h06, 3, 1'b1);
      send_seq(16'b01, 2);
      pulse_reset();
      send(1'b1);
      send(1'b0);
      chk("rst_mid_match", match, 0);
      chk("rst_mid_cnt", match_cnt, 0);

`ifdef SEQ_DETECT_MASK_EN
      cfg_mask = 8'h02;
      load(8'h06, 4, 1'b0);
      send_seq(16'b0100, 4);
      chk("mask_a", match, 1);
      send_seq(16'b0110, 4);
      chk("mask_b", match, 1);
      chk("mask_cnt", match_cnt, 2);
      cfg_mask = '0;
`endif

      // randomized traffic with occasional reconfiguration and clears
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
`ifdef SEQ_DETECT_MASK_EN
            cfg_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
`endif
            load(8'($urandom), (r < 2) ? $urandom_range(1, 3) : $urandom_range(0, 11),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 70),
                 1'b0, ($urandom_range(0, 99) < 3));
         end
      end

      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sb_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
